// File: rtl/maxadcspi_target_pkg.sv
// Shared encodings for the SPI config responder: FSM states, wishbone map
// and status bit positions.
package maxadcspi_target_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [7:0] ADR_STATUS  = 8'h00;
  localparam logic [7:0] ADR_FCNT    = 8'h01;
  localparam logic [7:0] ADR_REGBASE = 8'h80;

  localparam int ST_BUSY      = 0;
  localparam int ST_FRAME_ERR = 1;
  localparam int ST_WR_SEEN   = 2;
  localparam int ST_OVERRUN   = 3;

  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/maxadcspi_target_spi_input_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces
// registered single-cycle edge strobes plus a mosi copy aligned to them.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic sclk_hist_reg, mosi_hist_reg, cs_hist_reg;
  logic sclk_rise_reg, sclk_fall_reg, cs_fall_reg, cs_rise_reg;
  logic sclk_s, cs_s;

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];

  // cs chain resets high so a deselected bus never produces a false falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sclk_hist_reg <= 1'b0;
      mosi_hist_reg <= 1'b0;
      cs_hist_reg   <= 1'b1;
      sclk_rise_reg <= 1'b0;
      sclk_fall_reg <= 1'b0;
      cs_fall_reg   <= 1'b0;
      cs_rise_reg   <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs};
      sclk_hist_reg <= sclk_s;
      mosi_hist_reg <= mosi_sync_reg[SYNC_STAGES-1];
      cs_hist_reg   <= cs_s;
      sclk_rise_reg <= sclk_s & ~sclk_hist_reg;
      sclk_fall_reg <= ~sclk_s & sclk_hist_reg;
      cs_fall_reg   <= ~cs_s & cs_hist_reg;
      cs_rise_reg   <= cs_s & ~cs_hist_reg;
    end
  end

  assign sclk_rise = sclk_rise_reg;
  assign sclk_fall = sclk_fall_reg;
  assign cs_fall   = cs_fall_reg;
  assign cs_rise   = cs_rise_reg;
  assign mosi_s    = mosi_hist_reg;

endmodule

// File: rtl/maxadcspi_target.sv
// SPI mode-0 responder for 16-bit R/W+addr+data frames, backed by a small
// register file that is also visible on an 8-bit wishbone slave port.
module maxadcspi_target
  import maxadcspi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  output logic       miso_oe,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  input  logic       wb_we_i,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs        (cs),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  state_t      state_reg;
  logic [4:0]  bit_cnt_reg;
  logic [7:0]  shift_in_reg;
  logic [7:0]  shift_out_reg;
  logic        rw_reg;
  logic [6:0]  addr_reg;
  logic        loaded_reg;
  logic        miso_reg, miso_oe_reg;
  logic        frame_err_reg, wr_seen_reg, overrun_reg;
  logic [7:0]  fcnt_reg;
  logic [7:0]  reg_file [NUM_REGS];

  logic        addr_in_range;
  logic        data_rise;
  logic        frame_done;
  logic        spi_commit;
  logic [7:0]  commit_dat;
  logic [7:0]  rd_val;
  logic        wb_wr;
  logic        aborted;

  assign addr_in_range = 32'(addr_reg) < NUM_REGS;
  assign data_rise     = (state_reg == S_DATA) && sclk_rise && !cs_rise;
  assign frame_done    = data_rise && (bit_cnt_reg == 5'(FRAME_BITS - 1));
  assign spi_commit    = frame_done && !rw_reg && addr_in_range;
  assign commit_dat    = {shift_in_reg[6:0], mosi_s};
  assign rd_val        = addr_in_range ? reg_file[addr_reg[IDX_W-1:0]] : 8'h00;
  assign wb_wr         = wb_stb_i && wb_cyc_i && wb_we_i;
  assign aborted       = cs_rise && (state_reg != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      shift_in_reg  <= '0;
      shift_out_reg <= '0;
      rw_reg        <= 1'b0;
      addr_reg      <= '0;
      loaded_reg    <= 1'b0;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
    end else if (aborted) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      loaded_reg  <= 1'b0;
      miso_reg    <= 1'b0;
      miso_oe_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          bit_cnt_reg <= '0;
          loaded_reg  <= 1'b0;
          miso_oe_reg <= 1'b0;
          if (cs_fall) state_reg <= S_ADDR;
        end
        S_ADDR: begin
          if (sclk_rise) begin
            shift_in_reg <= {shift_in_reg[6:0], mosi_s};
            bit_cnt_reg  <= bit_cnt_reg + 5'd1;
            if (bit_cnt_reg == 5'd7) begin
              rw_reg    <= shift_in_reg[6];
              addr_reg  <= {shift_in_reg[5:0], mosi_s};
              state_reg <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // the counter saturates at the frame length; later bits are dropped
          if (data_rise && (32'(bit_cnt_reg) < FRAME_BITS)) begin
            shift_in_reg <= commit_dat;
            bit_cnt_reg  <= bit_cnt_reg + 5'd1;
          end
          if (sclk_fall && rw_reg) begin
            if (!loaded_reg) begin
              shift_out_reg <= rd_val;
              miso_reg      <= rd_val[7];
              miso_oe_reg   <= 1'b1;
              loaded_reg    <= 1'b1;
            end else begin
              shift_out_reg <= {shift_out_reg[6:0], 1'b0};
              miso_reg      <= shift_out_reg[6];
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // sticky flags: a same-cycle hardware set beats a wishbone clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      wr_seen_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
      fcnt_reg      <= '0;
    end else begin
      if (aborted && (32'(bit_cnt_reg) < FRAME_BITS))
        frame_err_reg <= 1'b1;
      else if (wb_wr && wb_adr_i == ADR_STATUS && wb_dat_i[ST_FRAME_ERR])
        frame_err_reg <= 1'b0;

      if (frame_done && !rw_reg)
        wr_seen_reg <= 1'b1;
      else if (wb_wr && wb_adr_i == ADR_STATUS && wb_dat_i[ST_WR_SEEN])
        wr_seen_reg <= 1'b0;

      if (data_rise && (32'(bit_cnt_reg) >= FRAME_BITS))
        overrun_reg <= 1'b1;
      else if (wb_wr && wb_adr_i == ADR_STATUS && wb_dat_i[ST_OVERRUN])
        overrun_reg <= 1'b0;

      if (frame_done) fcnt_reg <= fcnt_reg + 8'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          reg_file[gi] <= '0;
        else if (spi_commit && addr_reg[IDX_W-1:0] == IDX_W'(gi))
          reg_file[gi] <= commit_dat;
        else if (wb_wr && wb_adr_i == ADR_REGBASE + 8'(gi))
          reg_file[gi] <= wb_dat_i;
      end
    end
  endgenerate

  always_comb begin
    wb_dat_o = 8'h00;
    if (wb_adr_i == ADR_STATUS) begin
      wb_dat_o[ST_BUSY]      = (state_reg != S_IDLE);
      wb_dat_o[ST_FRAME_ERR] = frame_err_reg;
      wb_dat_o[ST_WR_SEEN]   = wr_seen_reg;
      wb_dat_o[ST_OVERRUN]   = overrun_reg;
    end else if (wb_adr_i == ADR_FCNT) begin
      wb_dat_o = fcnt_reg;
    end else if (wb_adr_i[7] && (32'(wb_adr_i[6:0]) < NUM_REGS)) begin
      wb_dat_o = reg_file[wb_adr_i[IDX_W-1:0]];
    end
  end

  assign miso     = miso_reg;
  assign miso_oe  = miso_oe_reg;
  assign wb_ack_o = 1'b1;

endmodule

// File: tb/tb_maxadcspi_target.sv
// Directed bench for maxadcspi_target: a vector table of SPI frames and
// wishbone accesses, then hand-written collision and mid-frame reset sequences.
module tb_maxadcspi_target;

  localparam int SYNC = 2;
  localparam int HALF = 80;
  localparam int K_SPI = 0, K_WBW = 1, K_WBR = 2;

  logic       clk, rst, sclk, mosi, cs;
  logic       miso, miso_oe;
  logic       wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [7:0] wb_adr_i, wb_dat_i, wb_dat_o;

  maxadcspi_target #(.SYNC_STAGES(SYNC), .NUM_REGS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs       (cs),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          nbits;
    logic [31:0] tx;
    logic [7:0]  adr;
    logic [7:0]  dat;
    logic [7:0]  exp;
    logic [31:0] exp_oe;
    bit          chk_rx;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(int k, int n, logic [31:0] tx, logic [7:0] a,
                              logic [7:0] d, logic [7:0] e, logic [31:0] eo,
                              bit c, string nm);
    vec_t v;
    v.kind = k; v.nbits = n; v.tx = tx; v.adr = a; v.dat = d;
    v.exp = e; v.exp_oe = eo; v.chk_rx = c; v.name = nm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = a; wb_dat_i = d;
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    wb_adr_i = a;
    #2;
    d = wb_dat_o;
  endtask

  // Host side of a mode-0 transfer; miso/miso_oe sampled just before each rising sclk.
  task automatic spi_xfer(input int n, input logic [31:0] tx, input bit raise_cs,
                          input bit coll, input logic [7:0] coll_dat,
                          output logic [31:0] rx, output logic [31:0] oe);
    rx = '0;
    oe = '0;
    @(negedge clk);
    cs = 1'b0;
    #HALF;
    for (int i = 0; i < n; i++) begin
      mosi = tx[n-1-i];
      #HALF;
      rx = {rx[30:0], miso};
      oe = {oe[30:0], miso_oe};
      sclk = 1'b1;
      if (coll && i == n - 1) begin
        // hold a wishbone write to reg 5 up to and including the SPI commit edge
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 8'h85; wb_dat_i = coll_dat;
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        #(HALF - (SYNC + 2) * 10);
      end else begin
        #HALF;
      end
      sclk = 1'b0;
    end
    mosi = 1'b0;
    if (raise_cs) begin
      #HALF;
      cs = 1'b1;
      #(2 * HALF);
    end
  endtask

  logic [7:0]  rd;
  logic [31:0] rx, oe;

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 8'h00; wb_dat_i = 8'h00;

    vecs.push_back(mk(K_WBR, 0, 0,        8'h00, 0, 8'h00, 0, 0, "rst_status"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h01, 0, 8'h00, 0, 0, "rst_fcnt"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h83, 0, 8'h00, 0, 0, "rst_reg3"));
    vecs.push_back(mk(K_SPI, 16, 32'h03A5, 0, 0, 8'h00, 32'h0, 0, "spi_wr_r3"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h83, 0, 8'hA5, 0, 0, "reg3_a5"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h00, 0, 8'h04, 0, 0, "status_wr_seen"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h01, 0, 8'h01, 0, 0, "fcnt_1"));
    vecs.push_back(mk(K_WBW, 0, 0,        8'h82, 8'h3C, 0, 0, 0, "wbw_r2"));
    vecs.push_back(mk(K_SPI, 16, 32'h8200, 0, 0, 8'h3C, 32'h00FF, 1, "spi_rd_r2"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h00, 0, 8'h04, 0, 0, "status_after_rd"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h01, 0, 8'h02, 0, 0, "fcnt_2"));
    vecs.push_back(mk(K_WBW, 0, 0,        8'h00, 8'h04, 0, 0, 0, "clr_wr_seen"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h00, 0, 8'h00, 0, 0, "status_cleared"));
    vecs.push_back(mk(K_SPI, 11, 32'h027, 0, 0, 8'h00, 32'h0, 0, "spi_short11"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h84, 0, 8'h00, 0, 0, "reg4_untouched"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h00, 0, 8'h02, 0, 0, "status_frame_err"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h01, 0, 8'h02, 0, 0, "fcnt_still_2"));
    vecs.push_back(mk(K_WBW, 0, 0,        8'h00, 8'h02, 0, 0, 0, "clr_frame_err"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h00, 0, 8'h00, 0, 0, "frame_err_cleared"));
    vecs.push_back(mk(K_SPI, 16, 32'h10AB, 0, 0, 8'h00, 32'h0, 0, "spi_wr_oob"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h80, 0, 8'h00, 0, 0, "reg0_no_alias"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h01, 0, 8'h03, 0, 0, "fcnt_3"));
    vecs.push_back(mk(K_SPI, 16, 32'h9000, 0, 0, 8'h00, 32'h00FF, 1, "spi_rd_oob"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h01, 0, 8'h04, 0, 0, "fcnt_4"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h02, 0, 8'h00, 0, 0, "unmapped_02"));
    vecs.push_back(mk(K_WBW, 0, 0,        8'h00, 8'h0F, 0, 0, 0, "clr_all"));
    vecs.push_back(mk(K_SPI, 18, 32'h15DF, 0, 0, 8'h00, 32'h0, 0, "spi_burst18"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h85, 0, 8'h77, 0, 0, "reg5_77"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h00, 0, 8'h0C, 0, 0, "status_overrun"));
    vecs.push_back(mk(K_WBR, 0, 0,        8'h01, 0, 8'h05, 0, 0, "fcnt_5"));

    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("ack_tied", 32'(wb_ack_o), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_WBR: begin
          wb_read(vecs[i].adr, rd);
          check(vecs[i].name, 32'(rd), 32'(vecs[i].exp));
        end
        K_WBW: begin
          wb_write(vecs[i].adr, vecs[i].dat);
          $display("wbw  %s: [0x%0h] <= 0x%0h", vecs[i].name, vecs[i].adr, vecs[i].dat);
        end
        default: begin
          spi_xfer(vecs[i].nbits, vecs[i].tx, 1'b1, 1'b0, 8'h00, rx, oe);
          if (vecs[i].chk_rx)
            check({vecs[i].name, "_miso"}, 32'(rx[7:0]), 32'(vecs[i].exp));
          check({vecs[i].name, "_oe"}, oe, vecs[i].exp_oe);
          check({vecs[i].name, "_oe_off"}, 32'(miso_oe), 32'd0);
        end
      endcase
    end

    // SPI commit and wishbone write to reg 5 land on the same clk
    spi_xfer(16, 32'h0511, 1'b1, 1'b1, 8'hEE, rx, oe);
    wb_read(8'h85, rd);
    check("collide_spi_wins", 32'(rd), 32'h11);
    wb_write(8'h85, 8'hEE);
    wb_read(8'h85, rd);
    check("wb_write_r5", 32'(rd), 32'hEE);

    // reset in the middle of a frame
    wb_write(8'h00, 8'h0F);
    spi_xfer(9, 32'h0C1, 1'b0, 1'b0, 8'h00, rx, oe);
    wb_read(8'h00, rd);
    check("busy_midframe", 32'(rd), 32'h01);
    @(negedge clk);
    rst = 1'b1;
    #20;
    check("midrst_miso_oe", 32'(miso_oe), 32'd0);
    wb_read(8'h83, rd);
    check("midrst_reg3", 32'(rd), 32'h00);
    wb_read(8'h82, rd);
    check("midrst_reg2", 32'(rd), 32'h00);
    wb_read(8'h85, rd);
    check("midrst_reg5", 32'(rd), 32'h00);
    wb_read(8'h00, rd);
    check("midrst_status", 32'(rd), 32'h00);
    wb_read(8'h01, rd);
    check("midrst_fcnt", 32'(rd), 32'h00);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    #40;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    wb_read(8'h00, rd);
    check("post_rst_status", 32'(rd), 32'h00);
    spi_xfer(16, 32'h0642, 1'b1, 1'b0, 8'h00, rx, oe);
    wb_read(8'h86, rd);
    check("post_rst_reg6", 32'(rd), 32'h42);
    wb_read(8'h01, rd);
    check("post_rst_fcnt", 32'(rd), 32'h01);
    wb_read(8'h00, rd);
    check("post_rst_wr_seen", 32'(rd), 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/maxadcspi_target.md
Name: maxadcspi_target

Overview:
- SPI responder (target) for the same 16-bit frame format our ADC configuration master sends: R/W bit, 7-bit address, 8-bit data, MSB first, mode 0, active-low cs.
- Oversamples the external sclk/mosi/cs in the clk domain and keeps a small register file that the SPI host can write and read back via miso.
- Exposes that register file, plus status and a frame counter, on the usual 8-bit wishbone slave port.
- Used as a loopback and simulation model for the ADC config path, and as a config target for an external controller.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer chain (minimum 2).
- NUM_REGS, 8, register file depth; must be a power of 2 and at most 128.

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst  input  1  asynchronous active-high reset.
- sclk  input  1  SPI clock from the host; asynchronous to clk.
- mosi  input  1  SPI data from the host; asynchronous.
- cs  input  1  SPI chip select from the host, active low; asynchronous.
- miso  output  1  SPI read data to the host.
- miso_oe  output  1  high while miso is being actively driven.
- wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  wishbone strobe, cycle and write enable.
- wb_adr_i  input  8  wishbone address.
- wb_dat_i  input  8  wishbone write data.
- wb_dat_o  output  8  wishbone read data, combinational from wb_adr_i.
- wb_ack_o  output  1  tied to 1; zero-wait-state access.

Behaviour:
- Reset: miso=0, miso_oe=0, register file=0, status=0, frame counter=0, FSM in S_IDLE, bit counter=0.
- Input synchronization:
  - sclk, mosi and cs each pass through SYNC_STAGES flops, then one extra history flop.
  - sclk edges are detected from the last synced value vs the history flop.
  - mosi uses the same delay as sclk, so a sample taken on a detected rising edge aligns with the host's data.
- FSM states: S_IDLE, S_ADDR, S_DATA.
  - S_IDLE: bit counter=0, miso_oe=0. Synced cs falling -> S_ADDR.
  - S_ADDR: on each rising sclk, shift mosi into an 8-bit register. On the 8th rising edge, latch rw = bit7 and addr = bits6:0, then go to S_DATA.
  - S_DATA, read frame (rw=1): on the next falling sclk, load the shift-out register with reg[addr] (0 if addr >= NUM_REGS), drive miso = its MSB and set miso_oe=1. Each later falling edge shifts miso left.
  - S_DATA, write frame (rw=0): shift mosi into the data register on each rising edge. On the 16th total rising edge, commit reg[addr] = data when addr < NUM_REGS; otherwise discard silently.
  - A frame completes on the 16th rising edge: frame counter +1 (8 bits, wraps 255 -> 0). A completed write also sets status.wr_seen.
  - More than 16 rising edges in one frame: extra bits are ignored and status.overrun is set.
- cs rising (synced) in any state:
  - Go to S_IDLE, miso_oe=0 on the next clk.
  - If fewer than 16 bits were received: set status.frame_err; no commit; counter unchanged.
- Simultaneous events:
  - Wishbone write and SPI commit to the same register in the same clk: SPI wins.
  - An SPI read returns the register value at the load cycle. A wishbone write landing in that same cycle is not seen by that read.
- Wishbone map:
  - 0x00 status: bit0 busy (state != S_IDLE), bit1 frame_err, bit2 wr_seen, bit3 overrun. Bits 1-3 are sticky; writing 1 clears them (write-1-to-clear).
  - 0x01 frame counter; read-only.
  - 0x80 + n: register n for n < NUM_REGS, read/write.
  - All other addresses read 0; writes to them are ignored.
- Latency: reg[addr] updates SYNC_STAGES+2 clk after the host's 16th sclk rising edge at the pins.

Decomposition:
- Shared package holds:
  - state encodings S_IDLE, S_ADDR, S_DATA;
  - wishbone addresses ADR_STATUS=0x00, ADR_FCNT=0x01, ADR_REGBASE=0x80;
  - status bit indices;
  - FRAME_BITS=16.
- One sub-module, spi_input_sync: synchronizer chain plus edge detect. Outputs sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s. Instantiated once.

Test Plan:
- SPI write frame 0x03,0xA5 -> wishbone read 0x83 = 0xA5; status = 0x04; 0x01 reads 1.
- Wishbone write 0x82 = 0x3C, then SPI read frame 0x82,0x00 -> miso shifts out 0x3C on bits 8-15; miso_oe high only in the data phase; miso_oe=0 after cs rises.
- Host raises cs after 11 bits -> no register change; status bit1 set; counter unchanged. Write 0x02 to 0x00 -> status bit1 cleared.
- Write to address 0x10 (>= NUM_REGS) -> no register change, counter +1. Read of 0x10 returns 0x00 on miso.
- 18-bit burst writing 0x05,0x77 -> reg 5 = 0x77, status bit3 set. Also: SPI commit and wishbone write to reg 5 in the same cycle -> SPI value kept.
- Assert rst mid-frame after 9 bits -> all registers and status 0, miso_oe=0. A following clean frame is decoded correctly.
